// File: rtl/otf_conv_pkg.sv
// Shared types and helpers for the on-the-fly converter scheduler:
// FSM state encoding, signed-digit constants and width helpers.
package otf_conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Signed-digit encoding used on the converter read side.
    localparam logic [1:0] DIGIT_POS  = 2'b10;
    localparam logic [1:0] DIGIT_NEG  = 2'b01;
    localparam logic [1:0] DIGIT_ZERO = 2'b00;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int cnt_width(input int frame_len, input int load_cyc);
        return $clog2(max2(frame_len, load_cyc) + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/otf_conv_scheduler_arb.sv
// Round-robin arbiter: combinational grant, registered priority pointer
// that moves to the requester after the one just granted.
module otf_rr_arbiter
    import otf_conv_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IW    = idx_width(N_REQ)
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [N_REQ-1:0] req,
    input  logic             enable,
    output logic [IW-1:0]    grant_idx,
    output logic             grant_valid
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] cand_idx;
    int            cand;

    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IW'(cand);
            if (enable && !grant_valid && req[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ptr <= '0;
        end else if (grant_valid) begin
            ptr <= (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/otf_conv_scheduler.sv
// Schedules requester words onto a shared on-the-fly converter: one frame at
// a time (IDLE/LOAD/STREAM/DONE), and tags returning digits with their owner.
module otf_conv_scheduler
    import otf_conv_pkg::*;
#(
    parameter  int N_REQ        = 4,
    parameter  int INT_WIDTH    = 8,
    parameter  int OFFSET_WIDTH = 4,
    parameter  int FRAME_LEN    = 12,
    parameter  int LOAD_CYC     = 3,
    localparam int DW           = INT_WIDTH + 1,
    localparam int TW           = idx_width(N_REQ)
) (
    input  logic                           i_clk,
    input  logic                           i_rstn,
    input  logic [N_REQ-1:0]               i_req,
    input  logic [N_REQ*DW-1:0]            i_req_data,
    input  logic [N_REQ*OFFSET_WIDTH-1:0]  i_req_offset,
    output logic [N_REQ-1:0]               o_ack,
    output logic                           o_busy,
    output logic                           o_conv_wen,
    output logic                           o_conv_wvalid,
    output logic                           o_conv_wlast,
    output logic signed [DW-1:0]           o_conv_wdata,
    output logic [OFFSET_WIDTH-1:0]        o_conv_woffset,
    input  logic [1:0]                     i_conv_rdata,
    input  logic                           i_conv_rvalid,
    input  logic                           i_conv_rlast,
    output logic [1:0]                     o_digit,
    output logic                           o_digit_valid,
    output logic                           o_digit_last,
    output logic [TW-1:0]                  o_digit_tag
);

    localparam int             CW         = cnt_width(FRAME_LEN, LOAD_CYC);
    localparam logic [CW-1:0]  LOAD_LAST  = CW'(LOAD_CYC - 1);
    localparam logic [CW-1:0]  FRAME_LAST = CW'(FRAME_LEN - 1);

    state_t                    state, state_nxt;
    logic [CW-1:0]             cnt, cnt_nxt;

    logic signed [DW-1:0]      req_data_arr [N_REQ];
    logic [OFFSET_WIDTH-1:0]   req_off_arr  [N_REQ];

    logic                      arb_en;
    logic [TW-1:0]             arb_idx;
    logic                      arb_valid;

    logic signed [DW-1:0]      wdata_p1;
    logic [OFFSET_WIDTH-1:0]   woffset_p1;
    logic [TW-1:0]             grant_p1;

    logic [TW-1:0]             tag_mem [2];
    logic                      wr_ptr, rd_ptr;
    logic [1:0]                fifo_cnt;
    logic                      fifo_full, fifo_empty;
    logic                      fifo_push, push_ok, pop_ok;
    logic                      fifo_err;

    logic [1:0]                digit_p1;
    logic                      digit_vld_p1;
    logic                      digit_last_p1;
    logic [TW-1:0]             tag_p1;

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign req_data_arr[k] = i_req_data[k*DW +: DW];
        assign req_off_arr[k]  = i_req_offset[k*OFFSET_WIDTH +: OFFSET_WIDTH];
    end

    assign arb_en = (state == ST_IDLE) && !fifo_full;

    otf_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .req         (i_req),
        .enable      (arb_en),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Counters restart at zero on every state change and saturate at the
    // terminal count, so they never wrap inside a state.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = '0;
        o_busy        = 1'b1;
        o_conv_wen    = 1'b0;
        o_conv_wvalid = 1'b0;
        o_conv_wlast  = 1'b0;
        o_ack         = '0;
        fifo_push     = 1'b0;
        case (state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (arb_valid) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (cnt == LOAD_LAST) begin
                    state_nxt = ST_STREAM;
                    fifo_push = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_STREAM: begin
                o_conv_wen    = 1'b1;
                o_conv_wvalid = 1'b1;
                if (cnt == FRAME_LAST) begin
                    o_conv_wlast = 1'b1;
                    state_nxt    = ST_DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_DONE: begin
                o_ack[grant_p1] = 1'b1;
                state_nxt       = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grant stage: operands are captured once so requester changes after
    // the grant cannot disturb the frame in flight.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wdata_p1   <= '0;
            woffset_p1 <= '0;
            grant_p1   <= '0;
        end else if (arb_valid) begin
            wdata_p1   <= req_data_arr[arb_idx];
            woffset_p1 <= req_off_arr[arb_idx];
            grant_p1   <= arb_idx;
        end
    end

    assign o_conv_wdata   = wdata_p1;
    assign o_conv_woffset = woffset_p1;

    assign fifo_full  = (fifo_cnt == 2'd2);
    assign fifo_empty = (fifo_cnt == 2'd0);
    assign pop_ok     = i_conv_rlast && !fifo_empty;
    assign push_ok    = fifo_push && (!fifo_full || pop_ok);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            tag_mem[0] <= '0;
            tag_mem[1] <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_cnt   <= 2'd0;
            fifo_err   <= 1'b0;
        end else begin
            if (push_ok) begin
                tag_mem[wr_ptr] <= grant_p1;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            if (i_conv_rlast && fifo_empty) begin
                fifo_err <= 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Sticky underflow flag is kept for debug probing only.
    logic unused_ok;
    assign unused_ok = &{1'b0, fifo_err};

    // Digit stage: one register between converter and consumer; the tag
    // follows the FIFO head and holds when no frame is outstanding.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            digit_p1      <= DIGIT_ZERO;
            digit_vld_p1  <= 1'b0;
            digit_last_p1 <= 1'b0;
            tag_p1        <= '0;
        end else begin
            digit_p1      <= i_conv_rdata;
            digit_vld_p1  <= i_conv_rvalid;
            digit_last_p1 <= i_conv_rlast;
            if (!fifo_empty) begin
                tag_p1 <= tag_mem[rd_ptr];
            end
        end
    end

    assign o_digit       = digit_p1;
    assign o_digit_valid = digit_vld_p1;
    assign o_digit_last  = digit_last_p1;
    assign o_digit_tag   = tag_p1;

endmodule

// File: tb/tb_otf_conv_scheduler.sv
// Scoreboard bench for otf_conv_scheduler: stimulus queues expected acks and
// digits, a negedge monitor pops and compares them as the DUT emits them.
module tb_otf_conv_scheduler;
    import otf_conv_pkg::*;

    localparam int N_REQ        = 4;
    localparam int INT_WIDTH    = 8;
    localparam int OFFSET_WIDTH = 4;
    localparam int FRAME_LEN    = 12;
    localparam int LOAD_CYC     = 3;
    localparam int DW           = INT_WIDTH + 1;

    logic                          i_clk = 1'b0;
    logic                          i_rstn;
    logic [N_REQ-1:0]              i_req;
    logic [N_REQ*DW-1:0]           i_req_data;
    logic [N_REQ*OFFSET_WIDTH-1:0] i_req_offset;
    logic [N_REQ-1:0]              o_ack;
    logic                          o_busy;
    logic                          o_conv_wen, o_conv_wvalid, o_conv_wlast;
    logic signed [DW-1:0]          o_conv_wdata;
    logic [OFFSET_WIDTH-1:0]       o_conv_woffset;
    logic [1:0]                    i_conv_rdata;
    logic                          i_conv_rvalid, i_conv_rlast;
    logic [1:0]                    o_digit;
    logic                          o_digit_valid, o_digit_last;
    logic [1:0]                    o_digit_tag;

    otf_conv_scheduler #(
        .N_REQ(N_REQ), .INT_WIDTH(INT_WIDTH), .OFFSET_WIDTH(OFFSET_WIDTH),
        .FRAME_LEN(FRAME_LEN), .LOAD_CYC(LOAD_CYC)
    ) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_req(i_req),
        .i_req_data(i_req_data), .i_req_offset(i_req_offset),
        .o_ack(o_ack), .o_busy(o_busy),
        .o_conv_wen(o_conv_wen), .o_conv_wvalid(o_conv_wvalid),
        .o_conv_wlast(o_conv_wlast), .o_conv_wdata(o_conv_wdata),
        .o_conv_woffset(o_conv_woffset),
        .i_conv_rdata(i_conv_rdata), .i_conv_rvalid(i_conv_rvalid),
        .i_conv_rlast(i_conv_rlast),
        .o_digit(o_digit), .o_digit_valid(o_digit_valid),
        .o_digit_last(o_digit_last), .o_digit_tag(o_digit_tag)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [1:0] d;
        logic [1:0] tag;
        logic       last;
    } dexp_t;

    dexp_t dq[$];
    int    aq[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic chk(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic set_req(input int k, input int val, input int off);
        i_req_data[k*DW +: DW]                     = DW'(val);
        i_req_offset[k*OFFSET_WIDTH +: OFFSET_WIDTH] = OFFSET_WIDTH'(off);
    endtask

    task automatic push_digit(input logic [1:0] d, input logic [1:0] tag, input logic last);
        dexp_t e;
        e.d = d; e.tag = tag; e.last = last;
        dq.push_back(e);
    endtask

    task automatic push_frame(input int k, input logic [1:0] d);
        aq.push_back(k);
        for (int i = 0; i < FRAME_LEN; i++) push_digit(d, 2'(k), (i == FRAME_LEN - 1));
    endtask

    task automatic wait_ack(input int maxc, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < maxc && !seen; i++) begin
            cyc(1);
            if (o_ack != '0) seen = 1'b1;
        end
        chk(seen, name, 32'(seen), 32'd1);
    endtask

    function automatic logic [31:0] all_outs();
        return {5'd0, o_ack, o_busy, o_conv_wen, o_conv_wvalid, o_conv_wlast,
                o_conv_wdata, o_conv_woffset, o_digit, o_digit_valid,
                o_digit_last, o_digit_tag};
    endfunction

    // Converter model: returns a sign digit of the written word 5 cycles later.
    logic       conv_auto;
    logic       man_v, man_l;
    logic [1:0] man_d;
    logic [4:0] pv, pl;
    logic [1:0] pd [5];

    function automatic logic [1:0] sign_digit(input logic signed [DW-1:0] w);
        if (w > 0) return DIGIT_POS;
        if (w < 0) return DIGIT_NEG;
        return DIGIT_ZERO;
    endfunction

    always @(negedge i_clk) begin
        if (!i_rstn) begin
            pv = '0; pl = '0;
            for (int i = 0; i < 5; i++) pd[i] = DIGIT_ZERO;
        end else begin
            for (int i = 4; i > 0; i--) pd[i] = pd[i-1];
            pd[0] = sign_digit(o_conv_wdata);
            pv = {pv[3:0], o_conv_wvalid};
            pl = {pl[3:0], o_conv_wlast};
        end
    end

    assign i_conv_rvalid = conv_auto ? pv[4] : man_v;
    assign i_conv_rlast  = conv_auto ? (pv[4] & pl[4]) : man_l;
    assign i_conv_rdata  = conv_auto ? pd[4] : man_d;

    // Monitor: every emitted digit and ack must match the head of its queue.
    always @(negedge i_clk) begin
        if (i_rstn) begin
            if (o_digit_valid) begin
                if (dq.size() == 0) begin
                    chk(1'b0, "digit_unexpected", {o_digit, o_digit_tag, o_digit_last}, 32'd0);
                end else begin
                    dexp_t e;
                    e = dq.pop_front();
                    chk({o_digit, o_digit_tag, o_digit_last} == e, "digit",
                        {o_digit, o_digit_tag, o_digit_last}, e);
                end
            end
            if (o_ack != '0) begin
                if (aq.size() == 0) begin
                    chk(1'b0, "ack_unexpected", o_ack, 32'd0);
                end else begin
                    int k;
                    k = aq.pop_front();
                    chk(o_ack == N_REQ'(1 << k), "ack", o_ack, 32'(1 << k));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_wen, exp_last;
        int n_acks, last_t, busy_seen;

        i_rstn = 1'b0; i_req = '0; i_req_data = '0; i_req_offset = '0;
        conv_auto = 1'b1; man_v = 1'b0; man_l = 1'b0; man_d = DIGIT_ZERO;

        // Reset state, including a request that must be ignored.
        cyc(2);
        chk(all_outs() == 32'd0, "reset_outputs", all_outs(), 32'd0);
        i_req = 4'b1111;
        cyc(1);
        chk(all_outs() == 32'd0, "reset_req_ignored", all_outs(), 32'd0);
        i_req = '0;
        i_rstn = 1'b1;
        cyc(1);

        // Single request: profile, data hold through a mid-frame change.
        set_req(0, 5, 9);
        push_frame(0, DIGIT_POS);
        i_req = 4'b0001;
        for (int c = 1; c <= 16; c++) begin
            cyc(1);
            exp_wen  = (c >= 4) && (c <= 15);
            exp_last = (c == 15);
            chk({o_busy, o_conv_wen, o_conv_wvalid, o_conv_wlast} == {1'b1, exp_wen, exp_wen, exp_last},
                "frame_profile", {o_busy, o_conv_wen, o_conv_wvalid, o_conv_wlast},
                {1'b1, exp_wen, exp_wen, exp_last});
            if (c <= 15)
                chk({o_conv_wdata, o_conv_woffset} == {9'd5, 4'd9}, "wdata_hold",
                    {o_conv_wdata, o_conv_woffset}, {9'd5, 4'd9});
            if (c == 9) set_req(0, -3, 9);
            if (c == 16) i_req = '0;
        end
        cyc(1);
        chk({o_busy, o_conv_wen} == 2'b00, "idle_after_done", {o_busy, o_conv_wen}, 32'd0);
        cyc(10);

        // Fairness from a fresh pointer: 0,1,2,3,0 at a 17-cycle period.
        i_rstn = 1'b0;
        cyc(1);
        i_rstn = 1'b1;
        set_req(0, 5, 1); set_req(1, -3, 2); set_req(2, 0, 3); set_req(3, -128, 4);
        push_frame(0, DIGIT_POS); push_frame(1, DIGIT_NEG);
        push_frame(2, DIGIT_ZERO); push_frame(3, DIGIT_NEG);
        push_frame(0, DIGIT_POS);
        i_req = 4'b1111;
        n_acks = 0; last_t = 0;
        for (int t = 1; t <= 120 && n_acks < 5; t++) begin
            cyc(1);
            if (o_ack != '0) begin
                if (n_acks == 0) chk(t == 16, "first_ack_time", t, 16);
                else chk(t - last_t == 17, "ack_period", t - last_t, 17);
                last_t = t;
                n_acks++;
                if (n_acks == 5) i_req = '0;
            end
        end
        chk(n_acks == 5, "fairness_ack_count", n_acks, 5);
        cyc(10);

        // Tag routing: requester 2 then requester 1 back-to-back.
        set_req(2, -4, 0); set_req(1, 9, 0);
        push_frame(2, DIGIT_NEG); push_frame(1, DIGIT_POS);
        i_req = 4'b0100;
        wait_ack(40, "ack_req2");
        i_req = 4'b0010;
        wait_ack(40, "ack_req1");
        i_req = '0;
        cyc(10);

        // FIFO full: converter holds rlast, third request must wait.
        conv_auto = 1'b0;
        set_req(0, 7, 0); set_req(3, -1, 0); set_req(2, 3, 0);
        aq.push_back(0); aq.push_back(3);
        i_req = 4'b0001;
        wait_ack(40, "ack_full_a");
        i_req = 4'b1000;
        wait_ack(40, "ack_full_b");
        i_req = 4'b0100;
        busy_seen = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (o_busy) busy_seen++;
        end
        chk(busy_seen == 0, "full_no_grant", busy_seen, 0);
        aq.push_back(2);
        push_digit(DIGIT_ZERO, 2'd0, 1'b1);
        man_d = DIGIT_ZERO; man_v = 1'b1; man_l = 1'b1;
        cyc(1);
        man_v = 1'b0; man_l = 1'b0;
        chk(!o_busy, "grant_not_early", o_busy, 0);
        cyc(1);
        chk(o_busy, "grant_after_pop", o_busy, 1);
        wait_ack(40, "ack_full_c");
        i_req = '0;
        cyc(2);
        push_digit(DIGIT_POS, 2'd3, 1'b1);
        man_d = DIGIT_POS; man_v = 1'b1; man_l = 1'b1;
        cyc(1); man_v = 1'b0; man_l = 1'b0; cyc(1);
        push_digit(DIGIT_NEG, 2'd2, 1'b1);
        man_d = DIGIT_NEG; man_v = 1'b1; man_l = 1'b1;
        cyc(1); man_v = 1'b0; man_l = 1'b0; cyc(1);
        push_digit(DIGIT_POS, 2'd2, 1'b1);   // pop on empty: tag holds
        man_d = DIGIT_POS; man_v = 1'b1; man_l = 1'b1;
        cyc(1); man_v = 1'b0; man_l = 1'b0; cyc(3);

        // Reset in STREAM cycle 6: outputs clear at once, frame never acked.
        set_req(2, 5, 0);
        i_req = 4'b0100;
        cyc(9);
        chk(o_conv_wen, "pre_reset_stream", o_conv_wen, 1);
        i_rstn = 1'b0;
        #1;
        chk(all_outs() == 32'd0, "reset_mid_stream", all_outs(), 32'd0);
        i_req = 4'b0010;
        set_req(1, -7, 0);
        cyc(2);
        chk(all_outs() == 32'd0, "held_in_reset", all_outs(), 32'd0);
        conv_auto = 1'b1;
        push_frame(1, DIGIT_NEG);
        i_rstn = 1'b1;
        wait_ack(40, "ack_after_reset");
        i_req = '0;
        cyc(12);

        chk(dq.size() == 0, "digit_queue_drained", dq.size(), 0);
        chk(aq.size() == 0, "ack_queue_drained", aq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/otf_conv_scheduler.md
OTF_CONV_SCHEDULER -- requirements
Module: otf_conv_scheduler

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- N_REQ, 4, number of requesters.
- INT_WIDTH, 8, integer magnitude width; data words are INT_WIDTH+1 bits, signed.
- OFFSET_WIDTH, 4, offset width.
- FRAME_LEN, 12, digit cycles per conversion frame.
- LOAD_CYC, 3, converter load cycles.

REQ-002 Ports (name, direction, width, meaning), one per line; clock and reset first:
- i_clk, in, 1, clock.
- i_rstn, in, 1, reset: asynchronous, active-low.
- i_req, in, N_REQ, per-requester request level.
- i_req_data, in, N_REQ*(INT_WIDTH+1), flat signed words; requester k occupies slice k.
- i_req_offset, in, N_REQ*OFFSET_WIDTH, flat offsets.
- o_ack, out, N_REQ, one-cycle completion pulse.
- o_busy, out, 1, high in any state other than IDLE.
- o_conv_wen, o_conv_wvalid, o_conv_wlast, out, 1 each, converter write controls.
- o_conv_wdata, out, INT_WIDTH+1, word sent to the converter.
- o_conv_woffset, out, OFFSET_WIDTH, offset sent to the converter.
- i_conv_rdata, in, 2, converter digit.
- i_conv_rvalid, i_conv_rlast, in, 1 each, converter digit valid and last.
- o_digit, out, 2, digit to consumer.
- o_digit_valid, o_digit_last, out, 1 each, digit valid and last to consumer.
- o_digit_tag, out, $clog2(N_REQ), requester index owning the current digit.

Function
REQ-003 The FSM SHALL have four states: IDLE, LOAD, STREAM, DONE.
REQ-004 In IDLE, when any i_req bit is high and the tag FIFO is not full, the round-robin arbiter SHALL grant one requester. On the next edge the FSM SHALL register that requester's data and offset and the grant index, then enter LOAD.
REQ-005 Round-robin: after requester k is granted, priority SHALL start at (k+1) mod N_REQ. After reset, requester 0 has highest priority.
REQ-006 LOAD SHALL last exactly LOAD_CYC cycles with o_conv_wen=o_conv_wvalid=0 and o_conv_wdata/o_conv_woffset driven from the registered values.
REQ-007 STREAM SHALL last exactly FRAME_LEN cycles with o_conv_wen=o_conv_wvalid=1. o_conv_wlast SHALL be 1 only in the final STREAM cycle.
REQ-008 On LOAD->STREAM the grant index SHALL be pushed into a 2-entry tag FIFO.
REQ-009 DONE SHALL last 1 cycle: o_ack[grant]=1, all converter controls 0. The FSM SHALL then return to IDLE. There is no back-to-back grant without passing through IDLE, which guarantees a write-enable-low gap of at least LOAD_CYC+1 cycles between frames.
REQ-010 i_req_data and i_req_offset SHALL be sampled only at grant; later changes SHALL not affect the frame in progress.
REQ-011 Requesters SHALL hold i_req until o_ack. A request deasserted before grant is simply not granted. A request deasserted after grant SHALL not abort the frame.
REQ-012 Digit path, 1-cycle registered: o_digit=i_conv_rdata, o_digit_valid=i_conv_rvalid, o_digit_last=i_conv_rlast. o_digit_tag SHALL be registered from the FIFO head.
REQ-013 The FIFO SHALL pop on the cycle i_conv_rlast=1.
- Simultaneous push and pop SHALL keep the count unchanged.
- A pop when empty SHALL be ignored and SHALL set a sticky internal error flag.
REQ-014 When the FIFO is full (2 frames outstanding), the FSM SHALL stay in IDLE and issue no grant.
REQ-015 When o_digit_valid=1 and the FIFO is empty, o_digit_tag SHALL hold its last value.
REQ-016 Counters SHALL be width $clog2(max(FRAME_LEN,LOAD_CYC)+1), load from zero on each state entry, and never wrap within a state.

Reset
REQ-017 Asserting i_rstn low at any time SHALL asynchronously return the FSM to IDLE, clear the counters, empty the FIFO, set the RR pointer to 0 and clear the error flag.
REQ-018 During reset, all outputs SHALL be 0: o_ack, o_busy, all o_conv_*, o_digit, o_digit_valid, o_digit_last, o_digit_tag.
REQ-019 A reset during STREAM SHALL abort the frame with no o_ack. After release, the first grant SHALL follow REQ-005.

Structure
REQ-020 Package otf_conv_pkg SHALL hold the FSM state enum, the digit encoding constants (signed-digit +1=2'b10, -1=2'b01, 0=2'b00) and the width helper functions.
REQ-021 The arbiter SHALL be the sub-module otf_rr_arbiter, parameterised by N_REQ, with inputs req and enable, and outputs grant_idx and grant_valid (combinational), plus a registered pointer updated on grant.

Verification
REQ-022 Single request: i_req=4'b0001, data=+5, offset=0 -> o_busy rises 1 cycle later; wen=0 for 3 cycles, then wen=1 for 12 cycles with wlast on cycle 12; o_ack[0] pulses 1 cycle after wlast.
REQ-023 Fairness: i_req=4'b1111 held -> grant order 0,1,2,3,0 and each o_ack appears exactly once per 17-cycle frame (1+3+12+1).
REQ-024 Tag routing: a converter model returns digits 5 cycles after wvalid; requesters 2 and 1 run back-to-back -> all of frame 2's digits carry tag 2, then all of frame 1's carry tag 1; o_digit_last coincides with the tag change.
REQ-025 FIFO full: converter model withholds rlast -> after 2 frames, o_busy=0 and no grant despite i_req=4'b0100; the third grant occurs 1 cycle after the first rlast.
REQ-026 Reset mid-STREAM: assert i_rstn=0 at STREAM cycle 6 -> all outputs 0 immediately and no o_ack; after release with i_req=4'b0010, requester 1 is granted first.
REQ-027 Data stability: change i_req_data[0] to -3 during STREAM -> o_conv_wdata stays +5 until the frame ends.
